// File: rtl/pipe_ctrl_unit_if.sv
// rtl/pipe_ctrl_unit_if.sv - ID/EX control handshake bundle for pipe_ctrl_unit
//
// Purpose: groups the decode-side handshake and the staged control words
// that pipe_ctrl_unit exchanges with the rest of the pipeline.
//
// Signals:
//   id_opcode    [5:0]  opcode of the instruction in ID
//   id_valid            id_opcode holds a real instruction
//   hazard_stall        load-use stall request from the hazard unit
//   flush               squash the instruction in ID
//   id_ready            ID instruction is accepted this cycle
//   fp_busy             float op in progress, ID blocked
//   ex_ctrl      [7:0]  {floatop, issigned, alusrc, regdst, aluop[3:0]}
//   mem_ctrl     [5:0]  {jal, jump, bne, beq, memwrite, memread}
//   wb_ctrl      [1:0]  {memtoreg, regwrite}
//   ex_illegal          instruction now in EX had an undefined opcode
//
// Modports: slave = the control unit, master = the pipeline driving ID.
interface pipe_ctrl_unit_if;
  logic [5:0] id_opcode;
  logic       id_valid;
  logic       hazard_stall;
  logic       flush;
  logic       id_ready;
  logic       fp_busy;
  logic [7:0] ex_ctrl;
  logic [5:0] mem_ctrl;
  logic [1:0] wb_ctrl;
  logic       ex_illegal;

  modport slave (
    input  id_opcode,
    input  id_valid,
    input  hazard_stall,
    input  flush,
    output id_ready,
    output fp_busy,
    output ex_ctrl,
    output mem_ctrl,
    output wb_ctrl,
    output ex_illegal
  );

  modport master (
    output id_opcode,
    output id_valid,
    output hazard_stall,
    output flush,
    input  id_ready,
    input  fp_busy,
    input  ex_ctrl,
    input  mem_ctrl,
    input  wb_ctrl,
    input  ex_illegal
  );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// rtl/pipe_ctrl_unit.sv - opcode decode, issue gating and staged control pipeline
//
// Purpose: decodes the opcode in ID into EX/MEM/WB control words, gates issue
// on stall/flush/float-busy, and carries the words down a three-stage control
// pipeline that advances every cycle. A small FSM blocks ID for FP_LAT-1
// cycles after a float op issues.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   pipe_ctrl_unit_if.slave (see interface file for the signal list)
//
// Parameters:
//   FP_LAT    float-op issue latency in cycles, 1..15
//   FLOAT_EN  1 enables opcode 6'h11 as a float op, 0 makes it illegal
module pipe_ctrl_unit #(
  parameter int FP_LAT   = 4,
  parameter bit FLOAT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  pipe_ctrl_unit_if.slave   bus
);

  localparam logic [3:0] CNT_LOAD = 4'(FP_LAT - 1);
  localparam bit         USE_BUSY = (FP_LAT > 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t     state, state_next;
  logic [3:0] cnt, cnt_next;

  // Decoded control fields for the instruction currently in ID.
  logic       dec_floatop;
  logic       dec_issigned;
  logic       dec_alusrc;
  logic       dec_regdst;
  logic [3:0] dec_aluop;
  logic       dec_jal;
  logic       dec_jump;
  logic       dec_bne;
  logic       dec_beq;
  logic       dec_memwrite;
  logic       dec_memread;
  logic       dec_memtoreg;
  logic       dec_regwrite;
  logic       dec_legal;

  logic       fp_busy;
  logic       id_ready;
  logic       issue;
  logic       issue_legal;

  // Control words as they sit in each stage.
  logic [7:0] ex_ctrl_q;
  logic [5:0] ex_mem_q;
  logic [1:0] ex_wb_q;
  logic       ex_illegal_q;
  logic [5:0] mem_ctrl_q;
  logic [1:0] mem_wb_q;
  logic [1:0] wb_ctrl_q;

  logic [7:0] ex_ctrl_d;
  logic [5:0] ex_mem_d;
  logic [1:0] ex_wb_d;

  // ---------------------------------------------------------------------------
  // Opcode decode
  // ---------------------------------------------------------------------------
  always_comb begin
    dec_floatop  = 1'b0;
    dec_issigned = 1'b0;
    dec_alusrc   = 1'b0;
    dec_regdst   = 1'b0;
    dec_aluop    = 4'h0;
    dec_jal      = 1'b0;
    dec_jump     = 1'b0;
    dec_bne      = 1'b0;
    dec_beq      = 1'b0;
    dec_memwrite = 1'b0;
    dec_memread  = 1'b0;
    dec_memtoreg = 1'b0;
    dec_regwrite = 1'b0;
    dec_legal    = 1'b1;

    case (bus.id_opcode)
      6'h12, 6'h22: begin  // lw, lbu
        dec_regwrite = 1'b1;
        dec_memtoreg = 1'b1;
        dec_memread  = 1'b1;
        dec_alusrc   = 1'b1;
        dec_issigned = 1'b1;
        dec_aluop    = 4'h4;
      end
      6'h0f: begin  // lui
        dec_regwrite = 1'b1;
        dec_alusrc   = 1'b1;
        dec_aluop    = 4'hb;
      end
      6'h28, 6'h2b: begin  // sb, sw
        dec_memwrite = 1'b1;
        dec_alusrc   = 1'b1;
        dec_issigned = 1'b1;
        dec_aluop    = 4'h4;
      end
      6'h03: begin  // R-type
        dec_regdst   = 1'b1;
        dec_regwrite = 1'b1;
        dec_aluop    = 4'h2;
      end
      6'h09: begin  // addi
        dec_regwrite = 1'b1;
        dec_alusrc   = 1'b1;
        dec_aluop    = 4'h4;
      end
      6'h0c: begin  // andi
        dec_regwrite = 1'b1;
        dec_alusrc   = 1'b1;
        dec_aluop    = 4'h5;
      end
      6'h0e: begin  // ori
        dec_regwrite = 1'b1;
        dec_alusrc   = 1'b1;
        dec_aluop    = 4'h3;
      end
      6'h05: begin  // branch on equal
        dec_beq      = 1'b1;
        dec_issigned = 1'b1;
        dec_aluop    = 4'h7;
      end
      6'h04: begin  // branch on not equal
        dec_bne      = 1'b1;
        dec_issigned = 1'b1;
        dec_aluop    = 4'h7;
      end
      6'h07: begin  // jal
        dec_jal      = 1'b1;
        dec_aluop    = 4'h4;
      end
      6'h02: begin  // j
        dec_jump     = 1'b1;
        dec_aluop    = 4'h0;
      end
      6'h11: begin  // float op, only when the FPU is configured in
        if (FLOAT_EN) begin
          dec_floatop  = 1'b1;
          dec_regdst   = 1'b1;
          dec_regwrite = 1'b1;
          dec_aluop    = 4'h2;
        end else begin
          dec_legal    = 1'b0;
        end
      end
      default: begin
        dec_legal    = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Issue gating
  // ---------------------------------------------------------------------------
  // id_ready deliberately ignores flush: the front end must not see a
  // combinational dependence on the branch-resolution path.
  assign fp_busy     = (state == BUSY);
  assign id_ready    = !fp_busy && !bus.hazard_stall;
  assign issue       = bus.id_valid && id_ready && !bus.flush;
  assign issue_legal = issue && dec_legal;

  // Illegal opcodes and non-issuing cycles both become all-zero bubbles.
  always_comb begin
    ex_ctrl_d = 8'h00;
    ex_mem_d  = 6'h00;
    ex_wb_d   = 2'b00;
    if (issue_legal) begin
      ex_ctrl_d = {dec_floatop, dec_issigned, dec_alusrc, dec_regdst, dec_aluop};
      ex_mem_d  = {dec_jal, dec_jump, dec_bne, dec_beq, dec_memwrite, dec_memread};
      ex_wb_d   = {dec_memtoreg, dec_regwrite};
    end
  end

  // ---------------------------------------------------------------------------
  // Float-busy FSM
  // ---------------------------------------------------------------------------
  // Only a float op that actually issues starts the count, so a float op held
  // back by hazard_stall or squashed by flush never blocks ID. Once BUSY, the
  // op is already in flight and flush has no effect on the count.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (USE_BUSY && issue_legal && dec_floatop) begin
          state_next = BUSY;
          cnt_next   = CNT_LOAD;
        end
      end
      BUSY: begin
        cnt_next = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Control pipeline: advances unconditionally every cycle
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_ctrl_q    <= 8'h00;
      ex_mem_q     <= 6'h00;
      ex_wb_q      <= 2'b00;
      ex_illegal_q <= 1'b0;
      mem_ctrl_q   <= 6'h00;
      mem_wb_q     <= 2'b00;
      wb_ctrl_q    <= 2'b00;
    end else begin
      ex_ctrl_q    <= ex_ctrl_d;
      ex_mem_q     <= ex_mem_d;
      ex_wb_q      <= ex_wb_d;
      ex_illegal_q <= issue && !dec_legal;
      mem_ctrl_q   <= ex_mem_q;
      mem_wb_q     <= ex_wb_q;
      wb_ctrl_q    <= mem_wb_q;
    end
  end

  assign bus.id_ready   = id_ready;
  assign bus.fp_busy    = fp_busy;
  assign bus.ex_ctrl    = ex_ctrl_q;
  assign bus.mem_ctrl   = mem_ctrl_q;
  assign bus.wb_ctrl    = wb_ctrl_q;
  assign bus.ex_illegal = ex_illegal_q;

endmodule
